// File: rtl/bsg_dmc_ui_initiator.sv
// bsg_dmc_ui_initiator
//   Initiator side of the bsg_dmc user interface. Turns a burst-granular
//   request stream into app_* transactions. A write moves ui_burst_len_p data
//   beats and then issues one command. A read issues one command and then
//   collects ui_burst_len_p returned beats into a local FIFO. The controller's
//   read channel cannot be stalled, so a read command is only issued when the
//   FIFO is guaranteed to have room for the whole burst (credit scheme).
//
// Ports
//   clk_i, reset_n_i          ui clock, asynchronous active-low reset
//   init_calib_complete_i     controller calibration done (gates new accepts)
//   req_*                     burst request channel (valid/ready)
//   wdata_*, wmask_i          write beat channel (valid/ready)
//   rdata_*                   read beat channel (valid/ready, last per burst)
//   app_*                     command / write-data / read-data to bsg_dmc
//   busy_o                    FSM active or read beats still outstanding
//   error_o                   sticky: read beat arrived with no read outstanding
module bsg_dmc_ui_initiator #(
    parameter int ui_addr_width_p = 28,
    parameter int ui_data_width_p = 32,
    parameter int ui_burst_len_p  = 8,
    parameter int rbuf_els_p      = 16
) (
    input  logic                          clk_i,
    input  logic                          reset_n_i,
    input  logic                          init_calib_complete_i,

    input  logic                          req_v_i,
    input  logic                          req_write_i,
    input  logic [ui_addr_width_p-1:0]    req_addr_i,
    output logic                          req_ready_o,

    input  logic                          wdata_v_i,
    input  logic [ui_data_width_p-1:0]    wdata_i,
    input  logic [(ui_data_width_p>>3)-1:0] wmask_i,
    output logic                          wdata_ready_o,

    output logic                          rdata_v_o,
    output logic [ui_data_width_p-1:0]    rdata_o,
    output logic                          rdata_last_o,
    input  logic                          rdata_ready_i,

    output logic [ui_addr_width_p-1:0]    app_addr_o,
    output logic [2:0]                    app_cmd_o,
    output logic                          app_en_o,
    input  logic                          app_rdy_i,
    output logic                          app_wdf_wren_o,
    output logic [ui_data_width_p-1:0]    app_wdf_data_o,
    output logic [(ui_data_width_p>>3)-1:0] app_wdf_mask_o,
    output logic                          app_wdf_end_o,
    input  logic                          app_wdf_rdy_i,
    input  logic                          app_rd_data_valid_i,
    input  logic [ui_data_width_p-1:0]    app_rd_data_i,
    input  logic                          app_rd_data_end_i,

    output logic                          busy_o,
    output logic                          error_o
);

    localparam int CW = $clog2(rbuf_els_p + 1);
    localparam int BW = $clog2(ui_burst_len_p);
    localparam int PW = (rbuf_els_p > 1) ? $clog2(rbuf_els_p) : 1;

    localparam logic [CW-1:0] BURST     = CW'(ui_burst_len_p);
    localparam logic [CW-1:0] DEPTH     = CW'(rbuf_els_p);
    localparam logic [BW-1:0] LAST_BEAT = BW'(ui_burst_len_p - 1);
    localparam logic [PW-1:0] LAST_PTR  = PW'(rbuf_els_p - 1);

    typedef enum logic [1:0] {IDLE, WR_DATA, WR_CMD, RD_CMD} state_e;
    typedef enum logic [2:0] {APP_CMD_WR = 3'd0, APP_CMD_RD = 3'd1} app_cmd_e;

    state_e                       state_q, state_d;
    logic [ui_addr_width_p-1:0]   addr_q, addr_d;
    app_cmd_e                     cmd_q, cmd_d;
    logic [BW-1:0]                beat_q, beat_d;
    logic [CW-1:0]                credits_q, credits_d;
    logic [CW-1:0]                outst_q, outst_d;
    logic [CW-1:0]                count_q;
    logic [PW-1:0]                wptr_q, rptr_q;
    logic [BW-1:0]                pop_cnt_q;
    logic                         error_q;
    // Low in reset and for the first clock after release so req_ready_o is
    // never asserted while reset is applied.
    logic                         active_q;

    logic [ui_data_width_p-1:0]   mem [rbuf_els_p];

    logic accept, grant_rd, push, pop, fifo_empty, in_wr;

    // The controller's end flag is redundant with our own beat count.
    logic unused_rd_end;
    assign unused_rd_end = app_rd_data_end_i;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            cmd_q    <= APP_CMD_WR;
            beat_q   <= '0;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            cmd_q    <= cmd_d;
            beat_q   <= beat_d;
            active_q <= 1'b1;
        end
    end

    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        cmd_d          = cmd_q;
        beat_d         = beat_q;
        accept         = 1'b0;
        grant_rd       = 1'b0;
        req_ready_o    = 1'b0;
        wdata_ready_o  = 1'b0;
        app_en_o       = 1'b0;
        app_cmd_o      = cmd_q;
        app_wdf_wren_o = 1'b0;
        app_wdf_end_o  = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready_o = active_q & init_calib_complete_i;
                accept      = req_v_i & active_q & init_calib_complete_i;
                if (accept) begin
                    addr_d  = req_addr_i;
                    cmd_d   = req_write_i ? APP_CMD_WR : APP_CMD_RD;
                    state_d = req_write_i ? WR_DATA : RD_CMD;
                end
            end
            WR_DATA: begin
                wdata_ready_o  = app_wdf_rdy_i;
                app_wdf_wren_o = wdata_v_i;
                app_wdf_end_o  = wdata_v_i & (beat_q == LAST_BEAT);
                if (wdata_v_i & app_wdf_rdy_i) begin
                    beat_d = beat_q + BW'(1);
                    if (beat_q == LAST_BEAT) state_d = WR_CMD;
                end
            end
            WR_CMD: begin
                app_en_o  = 1'b1;
                app_cmd_o = APP_CMD_WR;
                if (app_rdy_i) state_d = IDLE;
            end
            RD_CMD: begin
                // Only issue when the FIFO can absorb the whole burst.
                app_en_o = (credits_q >= BURST);
                if ((credits_q >= BURST) && app_rdy_i) begin
                    grant_rd = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_wr          = (state_q == WR_DATA);
    assign app_wdf_data_o = in_wr ? wdata_i : '0;
    assign app_wdf_mask_o = in_wr ? wmask_i : '0;
    assign app_addr_o     = addr_q;

    // ---------------------------------------------------------- read path
    assign fifo_empty = (count_q == '0);
    assign push       = app_rd_data_valid_i & (outst_q != '0);
    assign pop        = ~fifo_empty & rdata_ready_i;

    // Grant and pop may land in the same cycle; apply both as a net update.
    assign credits_d = credits_q - (grant_rd ? BURST : '0) + (pop ? CW'(1) : '0);
    assign outst_d   = outst_q + (grant_rd ? BURST : '0) - (push ? CW'(1) : '0);

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            credits_q <= DEPTH;
            outst_q   <= '0;
            count_q   <= '0;
            wptr_q    <= '0;
            rptr_q    <= '0;
            pop_cnt_q <= '0;
            error_q   <= 1'b0;
        end else begin
            credits_q <= credits_d;
            outst_q   <= outst_d;
            count_q   <= count_q + (push ? CW'(1) : '0) - (pop ? CW'(1) : '0);
            if (push) wptr_q <= (wptr_q == LAST_PTR) ? '0 : wptr_q + PW'(1);
            if (pop) begin
                rptr_q    <= (rptr_q == LAST_PTR) ? '0 : rptr_q + PW'(1);
                pop_cnt_q <= pop_cnt_q + BW'(1);
            end
            if (app_rd_data_valid_i && (outst_q == '0)) error_q <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem[wptr_q] <= app_rd_data_i;
    end

    assign rdata_v_o    = ~fifo_empty;
    assign rdata_o      = fifo_empty ? '0 : mem[rptr_q];
    assign rdata_last_o = ~fifo_empty & (pop_cnt_q == LAST_BEAT);
    assign busy_o       = (state_q != IDLE) | (outst_q != '0);
    assign error_o      = error_q;

endmodule

// File: doc/bsg_dmc_ui_initiator.md
Name: bsg_dmc_ui_initiator

Overview:
- Initiator side of the bsg_dmc user interface (app_* command, write-data and read-data channels).
- Converts a burst-granular request stream into app_* transactions:
  - write: ui_burst_len_p write-data beats, then one command;
  - read: one command, then collect ui_burst_len_p returned beats.
- Read data is buffered in a credit-managed FIFO, because the controller's read channel has no backpressure.
- Sits between on-chip traffic sources (cache, DMA) and bsg_dmc in the ui clock domain.

Parameters:
- ui_addr_width_p, 28, app address width
- ui_data_width_p, 32, app data width (multiple of 8); mask width = ui_data_width_p>>3
- ui_burst_len_p, 8, beats per burst (power of 2, >=2)
- rbuf_els_p, 16, read buffer depth in beats (>= ui_burst_len_p)

Ports:
- clk_i  in  1  ui clock
- reset_n_i  in  1  asynchronous active-low reset
- init_calib_complete_i  in  1  controller calibration done
- req_v_i  in  1  request valid
- req_write_i  in  1  1=write burst, 0=read burst
- req_addr_i  in  ui_addr_width_p  burst address
- req_ready_o  out  1  request accepted when req_v_i&req_ready_o
- wdata_v_i  in  1  write beat valid
- wdata_i  in  ui_data_width_p  write beat
- wmask_i  in  ui_data_width_p>>3  write mask (1=masked)
- wdata_ready_o  out  1  write beat consumed
- rdata_v_o  out  1  read beat valid
- rdata_o  out  ui_data_width_p  read beat
- rdata_last_o  out  1  last beat of a burst
- rdata_ready_i  in  1  consumer takes beat
- app_addr_o  out  ui_addr_width_p  to controller
- app_cmd_o  out  3  0=WR, 1=RD (app_cmd_e)
- app_en_o  out  1  command valid
- app_rdy_i  in  1  command accepted
- app_wdf_wren_o  out  1  write-data valid
- app_wdf_data_o  out  ui_data_width_p
- app_wdf_mask_o  out  ui_data_width_p>>3
- app_wdf_end_o  out  1  last write beat
- app_wdf_rdy_i  in  1
- app_rd_data_valid_i  in  1
- app_rd_data_i  in  ui_data_width_p
- app_rd_data_end_i  in  1  (ignored; beat count is authoritative)
- busy_o  out  1  state != IDLE or reads outstanding
- error_o  out  1  sticky: read beat received with no read outstanding

Behaviour:
- Reset: one clock, clk_i; reset is asynchronous, active-low on reset_n_i.
  - All state clears at once: FSM=IDLE, counters 0, credits=rbuf_els_p, buffer empty, error_o=0.
  - All outputs are 0 during reset.
- FSM states: IDLE, WR_DATA, WR_CMD, RD_CMD.
- IDLE:
  - req_ready_o = init_calib_complete_i.
  - On accept, register addr → app_addr_o and cmd → app_cmd_o.
  - Go to WR_DATA if write, else RD_CMD.
- WR_DATA:
  - wdata_ready_o = app_wdf_rdy_i.
  - app_wdf_wren_o = wdata_v_i.
  - Data and mask pass through combinationally.
  - Beat counter advances on wren&rdy.
  - app_wdf_end_o = wren when beat count == ui_burst_len_p-1.
  - On the last beat transfer, go to WR_CMD.
- WR_CMD:
  - app_en_o=1 and app_cmd_o=0.
  - app_en_o holds with stable addr/cmd until app_rdy_i, then IDLE.
- RD_CMD:
  - app_en_o = (credits >= ui_burst_len_p).
  - On app_en_o&app_rdy_i: credits -= ui_burst_len_p, outstanding_beats += ui_burst_len_p, go to IDLE.
  - No commands are pipelined: one request is in flight in the FSM at a time.
  - Multiple reads may be outstanding, limited by credits.
- Read path:
  - Every app_rd_data_valid_i pushes into the FIFO (depth rbuf_els_p) and decrements outstanding_beats.
  - Credits guarantee the FIFO never overflows.
  - Valid with outstanding_beats==0: set error_o and drop the beat.
- Read output:
  - rdata_v_o = FIFO not empty; rdata_o = FIFO head.
  - rdata_last_o is high on every ui_burst_len_p-th popped beat (pop counter mod burst).
  - Pop on rdata_v_o&rdata_ready_i; credits += 1.
- Same-cycle events: command grant (-burst) and pop (+1) apply in the same cycle; net update.
- Minimum latency: request accept to app_en_o is 1 cycle for a read; for a write, app_en_o follows the cycle after the last wdf beat.
- Calibration drop mid-operation: the current transaction completes; only new accepts are gated.
- Widths: credits and outstanding counters are $clog2(rbuf_els_p+1) bits wide.

Test Plan:
- Write burst, len 8: write at addr 0x100, data 0..7, app_wdf_rdy_i=1, app_rdy_i low for 3 cycles → 8 wren beats, end on beat 7; then app_en_o held 4 cycles with cmd=0, addr=0x100.
- Read burst: read at 0x200, controller returns 8 beats 0xA0..0xA7 → rdata_o yields the same order, rdata_last_o only on 0xA7, credits restored to 16.
- Credit stall: 3 reads issued, consumer rdata_ready_i=0 → the first 2 commands are issued and the third holds app_en_o=0; popping 8 beats releases it.
- Write backpressure: wdata_v_i toggles every cycle and app_wdf_rdy_i is low every 3rd cycle → exactly 8 beats transferred, no duplicates.
- Spurious data: app_rd_data_valid_i pulsed with no read outstanding → error_o=1 and stays set; FIFO unchanged.
- Async reset: reset_n_i asserted mid-WR_DATA (beat 4) → all outputs 0 immediately; after release, req_ready_o follows init_calib_complete_i.
